// File: rtl/jam_pkg.sv
// Shared widths and helpers for the job-assignment search engines
// and the cost ROM arbiter.
package jam_pkg;

  localparam int IDX_W    = 3;
  localparam int COST_W   = 7;
  localparam int SUM_W    = 10;
  localparam int COST_MAX = 100;

  // Up to four requesters; the highest set bit wins if several are set.
  function automatic logic [1:0] onehot_to_idx(
    input logic [3:0] oh
  );
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/cost_rom_arbiter_rr_pick.sv
// Rotating-priority picker: first asserted request at or after ptr,
// wrapping modulo N_REQ, returned as a one-hot grant.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt
);

  always_comb begin
    logic [PW:0]   s;
    logic [PW-1:0] idx;
    logic          found;
    gnt   = '0;
    found = 1'b0;
    s     = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s = {1'b0, ptr} + (PW+1)'(k);
      if (s >= (PW+1)'(N_REQ))
        s = s - (PW+1)'(N_REQ);
      idx = s[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cost_rom_arbiter.sv
// Round-robin arbiter sharing one cost ROM port among search engines,
// with lock ownership, a lock watchdog and tagged cost responses.
module cost_rom_arbiter
  import jam_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int LOCK_MAX = 15
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_lock,
  input  logic [IDX_W*N_REQ-1:0] req_w,
  input  logic [IDX_W*N_REQ-1:0] req_j,
  output logic [N_REQ-1:0]       req_ready,
  output logic [IDX_W-1:0]       W,
  output logic [IDX_W-1:0]       J,
  input  logic [COST_W-1:0]      Cost,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [COST_W-1:0]      rsp_cost,
  output logic                   owner_valid,
  output logic [1:0]             owner_id,
  output logic                   lock_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    own_q;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    pend_id;
  logic [N_REQ-1:0] gnt_rr;
  logic [N_REQ-1:0] own_oh;
  logic             pending;
  logic [CW-1:0]    wd_cnt;
  logic             own_req;
  logic             own_lock;
  logic             any_gnt;
  logic             grab;
  logic             expire;
  logic             release_now;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] j_sel;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] i
  );
    return (i == PW'(N_REQ-1)) ? '0 : i + PW'(1);
  endfunction

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt_rr)
  );

  assign own_oh   = N_REQ'(1) << own_q;
  assign own_req  = |(req_valid & own_oh);
  assign own_lock = |(req_lock & own_oh);

  assign req_ready = owner_valid
                   ? (own_req ? own_oh : '0)
                   : gnt_rr;

  assign any_gnt = |req_ready;
  assign gnt_idx = PW'(onehot_to_idx(4'(req_ready)));
  assign grab    = |(req_lock & req_ready);

  // An owner beat in the expiry cycle keeps the lock alive.
  assign expire = owner_valid & own_lock & ~own_req
                & (wd_cnt == CW'(LOCK_MAX-1));

  assign release_now = owner_valid & (~own_lock | expire);
  assign lock_err    = expire;
  assign owner_id    = 2'(own_q);

  always_comb begin
    w_sel = '0;
    j_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        w_sel = req_w[IDX_W*i +: IDX_W];
        j_sel = req_j[IDX_W*i +: IDX_W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      W       <= '0;
      J       <= '0;
      pending <= 1'b0;
      pend_id <= '0;
    end else begin
      pending <= any_gnt;
      if (any_gnt) begin
        W       <= w_sel;
        J       <= j_sel;
        pend_id <= gnt_idx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid <= '0;
      rsp_cost  <= '0;
    end else begin
      rsp_valid <= pending ? (N_REQ'(1) << pend_id) : '0;
      if (pending)
        rsp_cost <= Cost;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr      <= '0;
      owner_valid <= 1'b0;
      own_q       <= '0;
      wd_cnt      <= '0;
    end else if (release_now) begin
      owner_valid <= 1'b0;
      own_q       <= '0;
      rr_ptr      <= nxt(own_q);
      wd_cnt      <= '0;
    end else if (owner_valid) begin
      if (own_req)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + CW'(1);
    end else if (any_gnt) begin
      rr_ptr <= nxt(gnt_idx);
      if (grab) begin
        owner_valid <= 1'b1;
        own_q       <= gnt_idx;
        wd_cnt      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cost_rom_arbiter.sv
// Self-checking bench for cost_rom_arbiter with a W*10+J cost ROM
// and a response scoreboard.
module tb_cost_rom_arbiter;

  logic       CLK;
  logic       RST;
  logic [1:0] req_valid;
  logic [1:0] req_lock;
  logic [5:0] req_w;
  logic [5:0] req_j;
  logic [1:0] req_ready;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic [1:0] rsp_valid;
  logic [6:0] rsp_cost;
  logic       owner_valid;
  logic [1:0] owner_id;
  logic       lock_err;

  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic [1:0] l;
    logic [2:0] w0;
    logic [2:0] j0;
    logic [2:0] w1;
    logic [2:0] j1;
    logic [1:0] rdy;
    logic       ov;
    logic [1:0] oid;
    logic       le;
  } vec_t;

  typedef struct {
    int tag;
    int cost;
    int due;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mw    = 0;
  int   mj    = 0;
  int   mc    = 0;

  cost_rom_arbiter #(
    .N_REQ    (2),
    .LOCK_MAX (15)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_lock    (req_lock),
    .req_w       (req_w),
    .req_j       (req_j),
    .req_ready   (req_ready),
    .W           (W),
    .J           (J),
    .Cost        (Cost),
    .rsp_valid   (rsp_valid),
    .rsp_cost    (rsp_cost),
    .owner_valid (owner_valid),
    .owner_id    (owner_id),
    .lock_err    (lock_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb Cost = 7'(int'(W) * 10 + int'(J));

  function automatic vec_t mk(
    input int rst, input int v, input int l,
    input int w0, input int j0, input int w1, input int j1,
    input int rdy, input int ov, input int oid, input int le
  );
    vec_t t;
    t.rst = 1'(rst);
    t.v   = 2'(v);
    t.l   = 2'(l);
    t.w0  = 3'(w0);
    t.j0  = 3'(j0);
    t.w1  = 3'(w1);
    t.j1  = 3'(j1);
    t.rdy = 2'(rdy);
    t.ov  = 1'(ov);
    t.oid = 2'(oid);
    t.le  = 1'(le);
    return t;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input vec_t t);
    sb_t        e;
    logic [1:0] exp_rv;
    int         g;
    RST       = t.rst;
    req_valid = t.v;
    req_lock  = t.l;
    req_w     = {t.w1, t.w0};
    req_j     = {t.j1, t.j0};
    #2;
    exp_rv = 2'b00;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e      = sbq.pop_front();
      exp_rv = 2'(1 << e.tag);
      mc     = e.cost;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("rsp_cost", 32'(rsp_cost), mc);
    chk("W", 32'(W), mw);
    chk("J", 32'(J), mj);
    chk("req_ready", 32'(req_ready), 32'(t.rdy));
    chk("owner_valid", 32'(owner_valid), 32'(t.ov));
    chk("owner_id", 32'(owner_id), 32'(t.oid));
    chk("lock_err", 32'(lock_err), 32'(t.le));
    if (t.rst) begin
      sbq.delete();
      mw = 0;
      mj = 0;
      mc = 0;
    end else if (t.rdy != 2'b00) begin
      g     = t.rdy[1] ? 1 : 0;
      mw    = g ? int'(t.w1) : int'(t.w0);
      mj    = g ? int'(t.j1) : int'(t.j0);
      e.tag  = g;
      e.cost = mw * 10 + mj;
      e.due  = cyc + 2;
      sbq.push_back(e);
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    RST       = 1'b1;
    req_valid = '0;
    req_lock  = '0;
    req_w     = '0;
    req_j     = '0;

    // reset, single lookup, fairness, 8-beat lock
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3, 4, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2, 0, 0, 0, 1, 2, 2, 0, 0, 0));
    for (int r = 0; r < 6; r++)
      tbl.push_back(mk(0, 3, 0, r, r + 1, 7 - r, r,
                       (r % 2) ? 2 : 1, 0, 0, 0));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 5, 5, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 3, (k < 7) ? 2 : 0, 5, 5, k, 7 - k,
                       2, (k >= 1) ? 1 : 0, (k >= 1) ? 1 : 0, 0));
    tbl.push_back(mk(0, 3, 0, 2, 6, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(negedge CLK);
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i]);

    // watchdog: engine 0 locks then idles until forced release
    step(mk(0, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 15; k++)
      step(mk(0, 2, 1, 0, 0, 6, 6, 0, 1, 0, (k == 15) ? 1 : 0));
    step(mk(0, 2, 0, 0, 0, 6, 6, 2, 0, 0, 0));
    idle(2);

    // expiry cycle collides with an owner beat
    step(mk(0, 2, 2, 0, 0, 2, 3, 2, 0, 0, 0));
    for (int k = 1; k <= 14; k++)
      step(mk(0, 1, 2, 1, 1, 0, 0, 0, 1, 1, 0));
    step(mk(0, 3, 2, 1, 1, 6, 1, 2, 1, 1, 0));
    step(mk(0, 1, 2, 1, 1, 0, 0, 0, 1, 1, 0));
    step(mk(0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0));
    step(mk(0, 1, 0, 1, 7, 0, 0, 1, 0, 0, 0));
    idle(2);

    // reset one cycle after a locking grant
    step(mk(0, 1, 1, 7, 7, 0, 0, 1, 0, 0, 0));
    step(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 3, 0, 2, 2, 4, 4, 1, 0, 0, 0));
    idle(3);

    chk("sb_empty", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
